// File: rtl/win_min_pkg.sv
// Shared types and constants for the windowed-minimum block.
// WIN_MIN_ARGIDX_EN enables the argmin position output.
package win_min_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned IDX_W      = 8;

`ifdef WIN_MIN_ARGIDX_EN
    localparam bit ARGIDX_EN = 1'b1;
`else
    localparam bit ARGIDX_EN = 1'b0;
`endif

endpackage

// File: rtl/min_cmp.sv
// Unsigned compare of a candidate sample against the running minimum.
module min_cmp #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] i_cur,
    input  logic [DW-1:0] i_new,
    output logic [DW-1:0] o_min,
    output logic          o_replace
);

    // Strict less-than so an equal sample never displaces the current minimum.
    assign o_replace = (i_new < i_cur);
    assign o_min     = o_replace ? i_new : i_cur;

endmodule

// File: rtl/win_min.sv
// Minimum over fixed windows of WIN samples with valid/ready handshakes.
// Define WIN_MIN_ARGIDX_EN to add the out_idx argmin port.
module win_min
    import win_min_pkg::*;
#(
    parameter int unsigned DW  = DW_DEFAULT,
    parameter int unsigned WIN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_min
`ifdef WIN_MIN_ARGIDX_EN
    ,
    output logic [IDX_W-1:0] out_idx
`endif
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WIN);
    localparam state_e           FIRST_ST = (WIN == 1) ? HOLD : ACCUM;

    if (WIN < 1 || WIN > 255) begin : g_bad_win
        $error("win_min: WIN must be in 1..255");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DW-1:0]    r_min;
    logic [DW-1:0]    w_min_nxt;
    logic             r_out_valid;
    logic             w_accept;
    logic [DW-1:0]    w_cmp_min;
    logic             w_replace;
`ifdef WIN_MIN_ARGIDX_EN
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
`endif

    // While a result is held, a new sample may only enter as the result retires.
    assign in_ready  = !rst && ((r_state != HOLD) || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_min   = r_min;
`ifdef WIN_MIN_ARGIDX_EN
    assign out_idx   = r_idx;
`endif

    min_cmp #(.DW(DW)) u_cmp (
        .i_cur     (r_min),
        .i_new     (in_data),
        .o_min     (w_cmp_min),
        .o_replace (w_replace)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_min_nxt   = r_min;
`ifdef WIN_MIN_ARGIDX_EN
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = FIRST_ST;
                    w_cnt_nxt   = CNT_W'(1);
                    w_min_nxt   = in_data;
`ifdef WIN_MIN_ARGIDX_EN
                    w_idx_nxt   = '0;
`endif
                end
            end
            ACCUM: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_replace) begin
                        w_min_nxt = w_cmp_min;
`ifdef WIN_MIN_ARGIDX_EN
                        w_idx_nxt = IDX_W'(r_cnt);
`endif
                    end
                    if ((r_cnt + CNT_W'(1)) == WIN_C) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (w_accept) begin
                        // Retire and open the next window in the same cycle.
                        w_state_nxt = FIRST_ST;
                        w_cnt_nxt   = CNT_W'(1);
                        w_min_nxt   = in_data;
`ifdef WIN_MIN_ARGIDX_EN
                        w_idx_nxt   = '0;
`endif
                    end else begin
                        w_state_nxt = EMPTY;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = EMPTY;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_cnt       <= '0;
            r_min       <= '0;
            r_out_valid <= 1'b0;
`ifdef WIN_MIN_ARGIDX_EN
            r_idx       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_min       <= w_min_nxt;
            r_out_valid <= (w_state_nxt == HOLD);
`ifdef WIN_MIN_ARGIDX_EN
            r_idx       <= w_idx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_win_min.sv
// Scoreboard bench for win_min: WIN=4 and WIN=1 instances side by side.
module tb_win_min;

    typedef struct {
        logic [7:0] m;
        logic [7:0] i;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v4, rdy4, ov4, or4;
    logic [7:0] d4, om4;
    logic       v1, rdy1, ov1, or1;
    logic [7:0] d1, om1;
`ifdef WIN_MIN_ARGIDX_EN
    logic [7:0] oi4, oi1;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    win_min #(.DW(8), .WIN(4)) u_w4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v4),
        .in_data   (d4),
        .in_ready  (rdy4),
        .out_valid (ov4),
        .out_ready (or4),
        .out_min   (om4)
`ifdef WIN_MIN_ARGIDX_EN
        ,
        .out_idx   (oi4)
`endif
    );

    win_min #(.DW(8), .WIN(1)) u_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_data   (d1),
        .in_ready  (rdy1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_min   (om1)
`ifdef WIN_MIN_ARGIDX_EN
        ,
        .out_idx   (oi1)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Offer one sample to the WIN=4 instance and return just after it is taken.
    task automatic send4(input logic [7:0] d);
        int n = 0;
        v4 = 1'b1;
        d4 = d;
        @(negedge clk);
        while (!rdy4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send4_timeout", 0, 1);
        @(posedge clk);
        #1;
        v4 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d);
        int n = 0;
        v1 = 1'b1;
        d1 = d;
        @(negedge clk);
        while (!rdy1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send1_timeout", 0, 1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] m, input logic [7:0] i);
        exp_t e;
        e.m = m;
        e.i = i;
        q4.push_back(e);
    endtask

    task automatic push1(input logic [7:0] m);
        exp_t e;
        e.m = m;
        e.i = 8'd0;
        q1.push_back(e);
    endtask

    // Monitors: every output transfer must match the head of its queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_result", int'(om4), -1);
            end else begin
                e = q4.pop_front();
                chk("w4_out_min", int'(om4), int'(e.m));
`ifdef WIN_MIN_ARGIDX_EN
                chk("w4_out_idx", int'(oi4), int'(e.i));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ov1 && or1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_result", int'(om1), -1);
            end else begin
                e = q1.pop_front();
                chk("w1_out_min", int'(om1), int'(e.m));
`ifdef WIN_MIN_ARGIDX_EN
                chk("w1_out_idx", int'(oi1), int'(e.i));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1;
        v4 = 1'b0; d4 = 8'd0; or4 = 1'b1;
        v1 = 1'b0; d1 = 8'd0; or1 = 1'b1;
        @(negedge clk);
        chk("rst_in_ready_w4", int'(rdy4), 0);
        chk("rst_in_ready_w1", int'(rdy1), 0);
        idle(2);
        rst = 1'b0;
        chk("rst_out_valid_w4", int'(ov4), 0);
        chk("rst_out_min_w4", int'(om4), 0);
        chk("rst_out_valid_w1", int'(ov1), 0);
`ifdef WIN_MIN_ARGIDX_EN
        chk("rst_out_idx_w4", int'(oi4), 0);
`endif
        #1;
        chk("idle_in_ready_w4", int'(rdy4), 1);

        // 9,3,7,3: first 3 wins, valid the cycle after the 4th sample.
        push4(8'd3, 8'd1);
        send4(8'd9); send4(8'd3); send4(8'd7);
        chk("lat_no_early_valid", int'(ov4), 0);
        send4(8'd3);
        chk("lat_valid_after_4th", int'(ov4), 1);
        idle(1);
        chk("single_pulse", int'(ov4), 0);

        // Back-pressure: result held and input blocked until out_ready.
        or4 = 1'b0;
        push4(8'd25, 8'd3);
        send4(8'd200); send4(8'd100); send4(8'd50); send4(8'd25);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(ov4), 1);
            chk("stall_out_min", int'(om4), 25);
            chk("stall_in_ready", int'(rdy4), 0);
        end
        @(posedge clk);
        #1;
        or4 = 1'b1;
        #1;
        chk("in_ready_follows_out_ready", int'(rdy4), 1);
        idle(1);
        chk("hold_retired", int'(ov4), 0);

        // Continuous stream: two windows with no bubble between them.
        push4(8'd2, 8'd3);
        push4(8'd0, 8'd3);
        t0 = cyc;
        send4(8'd8); send4(8'd6); send4(8'd4); send4(8'd2);
        send4(8'd1); send4(8'd5); send4(8'd9); send4(8'd0);
        chk("stream_cycles", cyc - t0, 8);
        chk("stream_second_valid", int'(ov4), 1);
        idle(2);

        // Ties keep the first occurrence.
        push4(8'd5, 8'd0);
        send4(8'd5); send4(8'd5); send4(8'd5); send4(8'd5);
        push4(8'd2, 8'd1);
        send4(8'd4); send4(8'd2); send4(8'd2); send4(8'd3);
        idle(2);

        // Reset mid-window discards the partial window.
        send4(8'd5); send4(8'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", int'(rdy4), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", int'(ov4), 0);
        chk("midrst_out_min", int'(om4), 0);
        push4(8'd6, 8'd3);
        send4(8'd7); send4(8'd8); send4(8'd9); send4(8'd6);
        idle(2);

        // WIN=1: every sample is its own window.
        push1(8'hFF);
        push1(8'h00);
        send1(8'hFF);
        chk("w1_valid_after_first", int'(ov1), 1);
        send1(8'h00);
        chk("w1_valid_after_second", int'(ov1), 1);
        idle(3);
        chk("w1_idle_after", int'(ov1), 0);

        chk("w4_queue_drained", q4.size(), 0);
        chk("w1_queue_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
